// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and constants for the truth-table sweeper.
package truth_table_sweeper_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      APPLY  = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam int DEFAULT_NVARS  = 3;
   localparam int TT_W           = 2 ** DEFAULT_NVARS;
   localparam int DEFAULT_SETTLE = 1;

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Request/result bundle between a sweep controller and the function under test.
interface truth_table_sweeper_if
   import truth_table_sweeper_pkg::*;
   #(parameter int NVARS = DEFAULT_NVARS);

   localparam int TW = 2 ** NVARS;

   logic            start;
   logic [TW-1:0]   expected;
   logic            f;
   logic [NVARS-1:0] vars;
   logic            busy;
   logic            done;
   logic [TW-1:0]   truth;
   logic [NVARS:0]  ones;
   logic            match;

   modport master (
      output start, expected, f,
      input  vars, busy, done, truth, ones, match
   );

   modport slave (
      input  start, expected, f,
      output vars, busy, done, truth, ones, match
   );

endinterface

// File: rtl/truth_table_sweeper_tt_settle_timer.sv
// Loadable down-counter that holds at zero; measures the settle wait per vector.
module tt_settle_timer #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] load_value,
   output logic [W-1:0] value,
   output logic         zero
);

   logic [W-1:0] value_q;

   // Load has priority over decrement; the count never wraps below zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         value_q <= '0;
      end else if (load) begin
         value_q <= load_value;
      end else if (dec && (value_q != '0)) begin
         value_q <= value_q - W'(1);
      end
   end

   assign value = value_q;
   assign zero  = (value_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks a combinational function through every input vector, captures its
// truth table, counts minterms and compares against an expected table.
module truth_table_sweeper
   import truth_table_sweeper_pkg::*;
#(
   parameter int NVARS  = DEFAULT_NVARS,
   parameter int SETTLE = DEFAULT_SETTLE
) (
   input logic                 clk,
   input logic                 reset,
   truth_table_sweeper_if.slave bus
);

   localparam int TW    = 2 ** NVARS;
   localparam int CNT_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE);
   localparam logic [NVARS-1:0] LAST_IDX    = '1;

   state_t           state_q, state_d;
   logic             accept;
   logic             sample;
   logic             load_cnt;
   logic             dec_cnt;
   logic             cnt_zero;
   logic [CNT_W-1:0] cnt_value;
   logic             last_vec;

   logic [NVARS-1:0] idx_q;
   logic [TW-1:0]    truth_q;
   logic [TW-1:0]    exp_q;
   logic [NVARS:0]   ones_q;

   assign last_vec = (idx_q == LAST_IDX);

   tt_settle_timer #(.W(CNT_W)) u_timer (
      .clk        (clk),
      .reset      (reset),
      .load       (load_cnt),
      .dec        (dec_cnt),
      .load_value (SETTLE_LOAD),
      .value      (cnt_value),
      .zero       (cnt_zero)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and control strobes; the settle wait is reloaded whenever a
   // new vector is put on vars so f gets SETTLE+1 full cycles to settle.
   always_comb begin
      state_d  = state_q;
      accept   = 1'b0;
      sample   = 1'b0;
      load_cnt = 1'b0;
      dec_cnt  = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               accept   = 1'b1;
               load_cnt = 1'b1;
               state_d  = APPLY;
            end
         end
         APPLY: begin
            if (cnt_zero) begin
               state_d = SAMPLE;
            end else begin
               dec_cnt = (cnt_value != '0);
            end
         end
         SAMPLE: begin
            sample = 1'b1;
            if (last_vec) begin
               state_d = DONE;
            end else begin
               load_cnt = 1'b1;
               state_d  = APPLY;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Table capture, minterm count and vector index; a new sweep wipes any
   // previous result so a partial table never survives.
   always_ff @(posedge clk) begin
      if (reset) begin
         idx_q   <= '0;
         truth_q <= '0;
         exp_q   <= '0;
         ones_q  <= '0;
      end else if (accept) begin
         idx_q   <= '0;
         truth_q <= '0;
         exp_q   <= bus.expected;
         ones_q  <= '0;
      end else if (sample) begin
         truth_q[idx_q] <= bus.f;
         ones_q         <= ones_q + {{NVARS{1'b0}}, bus.f};
         if (!last_vec) begin
            idx_q <= idx_q + NVARS'(1);
         end
      end
   end

   assign bus.vars  = idx_q;
   assign bus.busy  = (state_q == APPLY) || (state_q == SAMPLE);
   assign bus.done  = (state_q == DONE);
   assign bus.truth = truth_q;
   assign bus.ones  = ones_q;
   assign bus.match = (state_q == DONE) && (truth_q == exp_q);

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: one sweeper with a settle wait of 1, one with no settle wait.
module tb_truth_table_sweeper;
   import truth_table_sweeper_pkg::*;

   logic clk;
   logic reset;
   int   checks   = 0;
   int   failures = 0;
   int   sel_a    = 0;
   int   sel_b    = 0;

   truth_table_sweeper_if #(.NVARS(3)) if_a ();
   truth_table_sweeper_if #(.NVARS(3)) if_b ();

   truth_table_sweeper #(.NVARS(3), .SETTLE(1)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (if_a.slave)
   );

   truth_table_sweeper #(.NVARS(3), .SETTLE(0)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (if_b.slave)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // sel 0: s = (x|y|~z)&(x|~y|z)&(x|~y|~z)&(~x|~y|~z); sel 1: const 0; sel 2: const 1.
   function automatic logic eval_f(input int sel, input logic [2:0] v);
      logic x, y, z;
      x = v[2];
      y = v[1];
      z = v[0];
      case (sel)
         1:       return 1'b0;
         2:       return 1'b1;
         default: return (x | y | ~z) & (x | ~y | z) & (x | ~y | ~z) & (~x | ~y | ~z);
      endcase
   endfunction

   // Functions under test, driven combinationally from each sweeper's vars.
   always_comb begin
      if_a.f = eval_f(sel_a, if_a.vars);
      if_b.f = eval_f(sel_b, if_b.vars);
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected_val);
      checks++;
      assert (observed === expected_val)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected_val);
      end
   endtask

   // Pulses start on sweeper A for one edge with the given expected table.
   task automatic apply_stimulus(input logic [TT_W-1:0] exp_tbl);
      if_a.expected = exp_tbl;
      if_a.start    = 1'b1;
      step(1);
      if_a.start    = 1'b0;
   endtask

   initial begin
      reset         = 1'b1;
      if_a.start    = 1'b0;
      if_a.expected = '0;
      if_b.start    = 1'b0;
      if_b.expected = '0;
      @(negedge clk);
      step(2);

      $display("[TB] reset state");
      check_output("rst_truth", 32'(if_a.truth), 32'h00);
      check_output("rst_ones",  32'(if_a.ones),  32'd0);
      check_output("rst_busy",  32'(if_a.busy),  32'd0);
      check_output("rst_done",  32'(if_a.done),  32'd0);
      check_output("rst_match", 32'(if_a.match), 32'd0);
      check_output("rst_vars",  32'(if_a.vars),  32'd0);
      reset = 1'b0;
      step(1);

      $display("[TB] PoS sweep, expected 0x71");
      sel_a = 0;
      apply_stimulus(8'h71);
      if_a.expected = 8'h00;
      step(23);
      check_output("pos_done_early", 32'(if_a.done), 32'd0);
      check_output("pos_busy_early", 32'(if_a.busy), 32'd1);
      step(1);
      check_output("pos_done",  32'(if_a.done),  32'd1);
      check_output("pos_busy",  32'(if_a.busy),  32'd0);
      check_output("pos_truth", 32'(if_a.truth), 32'h71);
      check_output("pos_ones",  32'(if_a.ones),  32'd4);
      check_output("pos_match", 32'(if_a.match), 32'd1);
      check_output("pos_vars",  32'(if_a.vars),  32'd7);

      $display("[TB] restart from DONE, expected 0x70");
      apply_stimulus(8'h70);
      check_output("rs_done_drop", 32'(if_a.done),  32'd0);
      check_output("rs_truth_clr", 32'(if_a.truth), 32'h00);
      check_output("rs_ones_clr",  32'(if_a.ones),  32'd0);
      check_output("rs_busy",      32'(if_a.busy),  32'd1);
      check_output("rs_match_lo",  32'(if_a.match), 32'd0);
      step(24);
      check_output("rs_done",  32'(if_a.done),  32'd1);
      check_output("rs_truth", 32'(if_a.truth), 32'h71);
      check_output("rs_match", 32'(if_a.match), 32'd0);

      $display("[TB] constant functions");
      sel_a = 1;
      apply_stimulus(8'h00);
      step(24);
      check_output("c0_truth", 32'(if_a.truth), 32'h00);
      check_output("c0_ones",  32'(if_a.ones),  32'd0);
      check_output("c0_match", 32'(if_a.match), 32'd1);
      sel_a = 2;
      apply_stimulus(8'hFF);
      step(24);
      check_output("c1_truth", 32'(if_a.truth), 32'hFF);
      check_output("c1_ones",  32'(if_a.ones),  32'd8);
      check_output("c1_match", 32'(if_a.match), 32'd1);

      $display("[TB] no settle wait");
      sel_b = 0;
      if_b.expected = 8'h71;
      if_b.start    = 1'b1;
      step(1);
      if_b.start    = 1'b0;
      for (int k = 0; k < 16; k++) begin
         check_output($sformatf("b_vars_%0d", k), 32'(if_b.vars), 32'(k / 2));
         check_output($sformatf("b_done_%0d", k), 32'(if_b.done), 32'd0);
         step(1);
      end
      check_output("b_done",  32'(if_b.done),  32'd1);
      check_output("b_truth", 32'(if_b.truth), 32'h71);
      check_output("b_ones",  32'(if_b.ones),  32'd4);
      check_output("b_match", 32'(if_b.match), 32'd1);
      check_output("b_vars",  32'(if_b.vars),  32'd7);

      $display("[TB] ignored start then mid-sweep reset");
      sel_a = 0;
      apply_stimulus(8'h71);
      step(5);
      check_output("mid_vars_5", 32'(if_a.vars), 32'd1);
      if_a.expected = 8'h00;
      if_a.start    = 1'b1;
      step(1);
      if_a.start    = 1'b0;
      check_output("mid_vars_6", 32'(if_a.vars), 32'd2);
      check_output("mid_busy_6", 32'(if_a.busy), 32'd1);
      step(3);
      check_output("mid_partial", 32'(if_a.truth), 32'h01);
      reset      = 1'b1;
      if_a.start = 1'b1;
      step(1);
      check_output("mr_truth", 32'(if_a.truth), 32'h00);
      check_output("mr_ones",  32'(if_a.ones),  32'd0);
      check_output("mr_busy",  32'(if_a.busy),  32'd0);
      check_output("mr_done",  32'(if_a.done),  32'd0);
      check_output("mr_match", 32'(if_a.match), 32'd0);
      check_output("mr_vars",  32'(if_a.vars),  32'd0);
      reset      = 1'b0;
      if_a.start = 1'b0;
      step(1);
      check_output("mr_idle", 32'(if_a.busy), 32'd0);
      apply_stimulus(8'h71);
      step(24);
      check_output("post_done",  32'(if_a.done),  32'd1);
      check_output("post_truth", 32'(if_a.truth), 32'h71);
      check_output("post_ones",  32'(if_a.ones),  32'd4);
      check_output("post_match", 32'(if_a.match), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
